// File: rtl/tristate_bus_ctrl.sv
// tristate_bus_ctrl: sequences a write stream and read strobes into drive/turnaround/sample phases on a shared tristate bus.
// Define TRISTATE_BUS_CTRL_CONTENTION_CHECK_EN to build the sticky bus-contention flag.
module tristate_bus_ctrl #(
   parameter int WIDTH        = 8,
   parameter int DRIVE_CYCLES = 2,
   parameter int TURNAROUND   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_req,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   input  logic [WIDTH-1:0] bus_in,
   output logic             err,
   output logic             busy
);
   localparam int MAXC = (DRIVE_CYCLES > TURNAROUND) ? DRIVE_CYCLES : ((TURNAROUND > 1) ? TURNAROUND : 1);
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] DRV_LOAD = CW'(DRIVE_CYCLES - 1);
   localparam logic [CW-1:0] TRN_LOAD = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

   typedef enum logic [1:0] {IDLE, DRIVE, TURN, READ} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] bus_out_q, bus_out_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             bus_oe_q, bus_oe_d;
   logic             rd_valid_q, rd_valid_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bus_out_d = bus_out_q;
      rd_data_d = rd_data_q;
      case (state_q)
         IDLE: begin
            if (wr_valid) begin
               state_d   = DRIVE;
               bus_out_d = wr_data;
               cnt_d     = DRV_LOAD;
            end else if (rd_req) begin
               state_d = READ;
            end
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               state_d = (TURNAROUND == 0) ? IDLE : TURN;
               cnt_d   = TRN_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         TURN: begin
            if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - CW'(1);
         end
         READ: begin
            state_d   = IDLE;
            rd_data_d = bus_in;
         end
         default: state_d = IDLE;
      endcase
      // Enable is a flop of the next state so it never glitches on the bus.
      bus_oe_d   = (state_d == DRIVE);
      rd_valid_d = (state_q == READ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bus_out_q  <= '0;
         rd_data_q  <= '0;
         bus_oe_q   <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bus_out_q  <= bus_out_d;
         rd_data_q  <= rd_data_d;
         bus_oe_q   <= bus_oe_d;
         rd_valid_q <= rd_valid_d;
      end
   end

`ifdef TRISTATE_BUS_CTRL_CONTENTION_CHECK_EN
   logic err_q, err_d;

   // Another agent fighting our drive shows up as a mismatch on the resolved net at the last drive edge.
   always_comb err_d = err_q | ((state_q == DRIVE) && (cnt_q == '0) && (bus_in != bus_out_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign wr_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign bus_out  = bus_out_q;
   assign bus_oe   = bus_oe_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
endmodule

// File: doc/tristate_bus_ctrl.md
# tristate_bus_ctrl

Sequencing controller that sits directly upstream of `tristate_buffer` and drives its data input `a` and enable `g` onto a shared bidirectional bus. It converts a valid/ready write stream and a read-request strobe into timed drive, turnaround and sample phases, so this side never drives the bus while another agent may. Read data is sampled from the resolved bus net (the buffer's `q`) and returned as a one-cycle pulse.

## Interface

- `WIDTH`, 8, bus and data width; ≥1.
- `DRIVE_CYCLES`, 2, cycles `bus_oe` stays high per write; ≥1.
- `TURNAROUND`, 1, idle cycles with `bus_oe` low after each write; ≥0.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`.
- `wr_data`  in  WIDTH  write payload.
- `rd_req`  in  1  read request; sampled only in IDLE.
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid.
- `rd_data`  out  WIDTH  captured bus value.
- `bus_out`  out  WIDTH  connects to `tristate_buffer.a`.
- `bus_oe`  out  1  connects to `tristate_buffer.g`.
- `bus_in`  in  WIDTH  resolved bus net (`tristate_buffer.q`).
- `err`  out  1  sticky contention flag.
- `busy`  out  1  high when state ≠ IDLE.

## Operation

- FSM states: IDLE, DRIVE, TURN, READ.
- IDLE: `wr_ready` = 1 (combinational on state). Handshake → DRIVE, `bus_out` ← `wr_data`, counter ← DRIVE_CYCLES-1. Else `rd_req` → READ. Write has priority when both are present; `rd_req` is not queued and must be held or re-asserted.
- DRIVE: `bus_oe` = 1. At counter 0 → TURN (counter ← TURNAROUND-1), or → IDLE if TURNAROUND = 0. Otherwise decrement.
- TURN: `bus_oe` = 0, `bus_out` holds. At counter 0 → IDLE.
- READ: `bus_oe` = 0 for one cycle. At the closing edge, `rd_data` ← `bus_in`, `rd_valid` ← 1, → IDLE.
- `wr_ready` = 0 in DRIVE, TURN and READ. `bus_oe` is registered and glitch-free.
- Counter width: `$clog2(max(DRIVE_CYCLES, TURNAROUND, 1) + 1)`, unsigned. It never underflows.
- `rd_data` holds its last value between reads.
- Reset values: state IDLE, `bus_oe` 0, `bus_out` 0, `rd_data` 0, `rd_valid` 0, `err` 0, `busy` 0, `wr_ready` 1 after release.
- Reset mid-DRIVE releases the bus immediately (asynchronous). The in-flight write is dropped.

## Timing

- Write accepted at edge N: `bus_oe` high during cycles N+1 … N+DRIVE_CYCLES, low during the following TURNAROUND cycles. `wr_ready` returns high in cycle N+DRIVE_CYCLES+TURNAROUND+1.
- Back-to-back writes: minimum spacing is DRIVE_CYCLES+TURNAROUND+1 cycles.
- Read accepted at edge N: READ during cycle N+1. `rd_valid` is high in cycle N+2, which is in IDLE, so a new request is accepted in that same cycle.
- Read following a write always sees at least TURNAROUND cycles of `bus_oe` low, plus the READ cycle itself.

## Configuration

- `TRISTATE_BUS_CTRL_CONTENTION_CHECK_EN` defined:
  - At the last DRIVE cycle's closing edge, if `bus_in` ≠ `bus_out`, set `err`.
  - `err` is sticky until `rst`.
- Not defined: `err` is tied to 0, and no compare logic is built.

## Test plan

- Reset: assert `rst` mid-DRIVE → `bus_oe` drops to 0 in the same cycle; after release, all outputs are at their reset values and `wr_ready` = 1.
- Write 8'hA5, DRIVE_CYCLES = 2, TURNAROUND = 1 → `bus_oe` high 2 cycles with `bus_in` = 8'hA5, low 1 cycle, `wr_ready` back high in the 4th cycle after the handshake.
- Read with an external driver holding 8'h3C on an idle bus → `rd_valid` pulses exactly one cycle, 2 cycles after the request, with `rd_data` = 8'h3C.
- Simultaneous `wr_valid` + `rd_req` in IDLE → write serviced first. Read serviced once `rd_req` is re-seen in IDLE, and only after TURN completes.
- TURNAROUND = 0, two back-to-back writes 8'h01, 8'h02 → 3-cycle spacing, `bus_oe` continuously high except the single IDLE cycle between them.
- With the `_EN` macro, an external agent forces 8'hFF while writing 8'h00 → `err` = 1 and stays 1 until `rst`. Without the macro, `err` stays 0.
